// File: rtl/bsk_prm_pkg.sv
// Shared types and constants for the BskPRM parallel peripheral bus.
package bsk_prm_pkg;

  localparam int BSK_ADDR_W = 2;
  localparam int BSK_DATA_W = 16;

  // Register map of the peripheral on the far side of the bus
  localparam logic [BSK_ADDR_W-1:0] REG_COM_T   = 2'b00;
  localparam logic [BSK_ADDR_W-1:0] REG_COM     = 2'b01;
  localparam logic [BSK_ADDR_W-1:0] REG_COM_IND = 2'b10;
  localparam logic [BSK_ADDR_W-1:0] REG_CTRL    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/bsk_prm_bus_master.sv
// BskPRM bus initiator: turns single-word valid/ready requests into
// setup / strobe / hold bus cycles and returns a one-clock response pulse.
// Every output is a flop; the pin-level tri-state buffer lives outside.
module bsk_prm_bus_master
  import bsk_prm_pkg::*;
#(
  parameter logic [3:0] CS_CODE  = 4'b0111,
  parameter int         T_SETUP  = 2,
  parameter int         T_STROBE = 4,
  parameter int         T_HOLD   = 2,
  parameter int         CNT_W    = 4
) (
  input  logic                  iClk,
  input  logic                  iRes,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic                  iReqWr,
  input  logic [BSK_ADDR_W-1:0] iReqA,
  input  logic [BSK_DATA_W-1:0] iReqD,
  output logic                  oRspValid,
  output logic                  oRspWr,
  output logic [BSK_DATA_W-1:0] oRspD,
  output logic [3:0]            oCS,
  output logic [BSK_ADDR_W-1:0] oA,
  output logic                  oRd,
  output logic                  oWr,
  output logic [BSK_DATA_W-1:0] oD,
  output logic                  oDOe,
  input  logic [BSK_DATA_W-1:0] iD
);

  // Counter reload values: a phase of T clocks counts T-1 down to 0
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(T_HOLD - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    wr_q;   // type of the cycle in flight
  logic [BSK_DATA_W-1:0]   rd_q;   // bus data captured at the end of the strobe

  // Cycle sequencer: phase FSM, phase counter and all registered outputs
  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      oReqReady <= 1'b0;
      oRspValid <= 1'b0;
      oRspWr    <= 1'b0;
      oRspD     <= '0;
      oCS       <= ~CS_CODE;
      oA        <= '0;
      oRd       <= 1'b1;
      oWr       <= 1'b1;
      oD        <= '0;
      oDOe      <= 1'b0;
    end else begin
      oRspValid <= 1'b0;
      case (state)
        IDLE: begin
          // Ready is a flop, so the handshake uses its registered value
          if (oReqReady && iReqValid) begin
            wr_q      <= iReqWr;
            oA        <= iReqA;
            oCS       <= CS_CODE;
            oReqReady <= 1'b0;
            cnt       <= LD_SETUP;
            state     <= SETUP;
            if (iReqWr) begin
              oD   <= iReqD;
              oDOe <= 1'b1;
            end
          end else begin
            oReqReady <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            oRd   <= wr_q;
            oWr   <= ~wr_q;
            cnt   <= LD_STROBE;
            state <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            // Read data is valid on the bus while the strobe is still low
            if (!wr_q) rd_q <= iD;
            oRd   <= 1'b1;
            oWr   <= 1'b1;
            cnt   <= LD_HOLD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            oCS       <= ~CS_CODE;
            oDOe      <= 1'b0;
            oRspValid <= 1'b1;
            oRspWr    <= wr_q;
            oReqReady <= 1'b1;
            if (!wr_q) oRspD <= rd_q;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsk_prm_bus_master.sv
// Bench for bsk_prm_bus_master: scoreboard of expected responses plus
// hand-written timing sequences; a second instance uses 1-clock phases.
module tb_bsk_prm_bus_master;

  typedef struct packed {
    logic        wr;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] rdv;   // value the bus model returns for a read of a
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        wr_i = 1'b0;
  logic [1:0]  a_i = 2'b00;
  logic [15:0] d_i = 16'h0000;
  logic [15:0] mem [4];

  logic        x0_rdy, x0_rspv, x0_rspwr, x0_rd, x0_wr, x0_doe;
  logic [15:0] x0_rspd, x0_d, id0;
  logic [3:0]  x0_cs;
  logic [1:0]  x0_a;
  logic        x1_rdy, x1_rspv, x1_rspwr, x1_rd, x1_wr, x1_doe;
  logic [15:0] x1_rspd, x1_d, id1;
  logic [3:0]  x1_cs;
  logic [1:0]  x1_a;

  int pass_cnt = 0, total_cnt = 0, viol = 0;
  exp_t q[$];
  logic [15:0] last_rd = 16'h0000;
  vec_t vecs [7];

  // Bus model: the addressed register drives data only while RD is low
  assign id0 = x0_rd ? 16'h1234 : mem[x0_a];
  assign id1 = x1_rd ? 16'h1234 : mem[x1_a];

  always #5 clk = ~clk;

  bsk_prm_bus_master dut0 (
    .iClk(clk), .iRes(rst_n), .iReqValid(v0), .oReqReady(x0_rdy),
    .iReqWr(wr_i), .iReqA(a_i), .iReqD(d_i), .oRspValid(x0_rspv),
    .oRspWr(x0_rspwr), .oRspD(x0_rspd), .oCS(x0_cs), .oA(x0_a),
    .oRd(x0_rd), .oWr(x0_wr), .oD(x0_d), .oDOe(x0_doe), .iD(id0));

  bsk_prm_bus_master #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) dut1 (
    .iClk(clk), .iRes(rst_n), .iReqValid(v1), .oReqReady(x1_rdy),
    .iReqWr(wr_i), .iReqA(a_i), .iReqD(d_i), .oRspValid(x1_rspv),
    .oRspWr(x1_rspwr), .oRspD(x1_rspd), .oCS(x1_cs), .oA(x1_a),
    .oRd(x1_rd), .oWr(x1_wr), .oD(x1_d), .oDOe(x1_doe), .iD(id1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Called just after a falling edge; returns on the accepting rising edge
  task automatic issue(input logic w, input logic [1:0] aa, input logic [15:0] dd,
                       input logic [15:0] rv);
    int n;
    exp_t e;
    n = 0;
    wr_i = w; a_i = aa; d_i = dd; v0 = 1'b1;
    while (!x0_rdy && n < 50) begin @(negedge clk); n++; end
    if (!x0_rdy) chk("ready_timeout", 32'd0, 32'd1);
    else begin
      e.wr = w;
      e.d  = w ? last_rd : rv;
      if (!w) last_rd = rv;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  // Scoreboard consumer and per-clock protocol watch
  always @(negedge clk) begin : mon
    exp_t e;
    if (!x0_rd && !x0_wr) viol++;
    if (x0_doe && !x0_rd) viol++;
    if (!x1_rd && !x1_wr) viol++;
    if (x0_rspv) begin
      if (q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("rsp_wr", 32'(x0_rspwr), 32'(e.wr));
        chk("rsp_d", 32'(x0_rspd), 32'(e.d));
      end
    end
  end

  initial begin
    int cs_cnt, cs_first, st_cnt, st_first, doe_cnt, d_ok, rsp_at, rd_low, rdy_low, n;
    exp_t e;
    mem[0] = 16'h0F0F; mem[1] = 16'h1111; mem[2] = 16'hBEEF; mem[3] = 16'hA693;
    vecs[0] = '{1'b1, 2'd0, 16'hA5C3, 16'h0000};
    vecs[1] = '{1'b0, 2'd3, 16'h0000, 16'hA693};
    vecs[2] = '{1'b1, 2'd2, 16'h5555, 16'h0000};
    vecs[3] = '{1'b0, 2'd0, 16'h0000, 16'h0F0F};
    vecs[4] = '{1'b0, 2'd2, 16'h0000, 16'hBEEF};
    vecs[5] = '{1'b1, 2'd1, 16'hFFFF, 16'h0000};
    vecs[6] = '{1'b0, 2'd1, 16'h0000, 16'h1111};

    // Reset values
    #12;
    chk("rst_cs", 32'(x0_cs), 32'h8);
    chk("rst_strobes", 32'({x0_rd, x0_wr}), 32'h3);
    chk("rst_doe_d_a", 32'({x0_doe, x0_d, x0_a}), 32'h0);
    chk("rst_rdy_rsp", 32'({x0_rdy, x0_rspv, x0_rspwr, x0_rspd}), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(x0_rdy), 32'd1);

    // Write at defaults, timed per clock
    issue(1'b1, 2'd0, 16'hA5C3, 16'h0);
    cs_cnt = 0; cs_first = 0; st_cnt = 0; st_first = 0; doe_cnt = 0; d_ok = 0;
    rsp_at = 0; rd_low = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) v0 = 1'b0;
      if (x0_cs == 4'b0111) begin cs_cnt++; if (cs_first == 0) cs_first = k; end
      if (!x0_wr) begin st_cnt++; if (st_first == 0) st_first = k; end
      if (x0_doe) begin doe_cnt++; if (x0_d == 16'hA5C3) d_ok++; end
      if (x0_rspv && rsp_at == 0) rsp_at = k;
      if (!x0_rd) rd_low++;
    end
    chk("wr_cs_clocks", 32'(cs_cnt), 32'd8);
    chk("wr_cs_first", 32'(cs_first), 32'd1);
    chk("wr_strobe_clocks", 32'(st_cnt), 32'd4);
    chk("wr_strobe_first", 32'(st_first), 32'd3);
    chk("wr_doe_clocks", 32'(doe_cnt), 32'd8);
    chk("wr_data_ok", 32'(d_ok), 32'd8);
    chk("wr_rsp_at", 32'(rsp_at), 32'd9);
    chk("wr_rd_low", 32'(rd_low), 32'd0);
    drain();

    // Read REG_CTRL
    issue(1'b0, 2'd3, 16'h0, 16'hA693);
    doe_cnt = 0; rd_low = 0; rsp_at = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) v0 = 1'b0;
      if (x0_doe) doe_cnt++;
      if (!x0_rd) rd_low++;
      if (x0_rspv && rsp_at == 0) rsp_at = k;
    end
    chk("rd_doe_clocks", 32'(doe_cnt), 32'd0);
    chk("rd_strobe_clocks", 32'(rd_low), 32'd4);
    chk("rd_rsp_at", 32'(rsp_at), 32'd9);
    drain();

    // Table of mixed transactions
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].rdv);
      @(negedge clk); v0 = 1'b0;
      drain();
    end

    // Back-to-back: valid held across write then read
    issue(1'b1, 2'd2, 16'h6699, 16'h0);
    @(negedge clk); wr_i = 1'b0; a_i = 2'd0;
    n = 0;
    while (!x0_rspv && n < 20) begin @(negedge clk); n++; end
    chk("b2b_rsp_seen", 32'(x0_rspv), 32'd1);
    chk("b2b_cs_gap", 32'(x0_cs), 32'h8);
    chk("b2b_rdy_on_rsp", 32'(x0_rdy), 32'd1);
    e.wr = 1'b0; e.d = mem[0]; last_rd = mem[0]; q.push_back(e);
    @(posedge clk);
    @(negedge clk); v0 = 1'b0;
    chk("b2b_cs_second", 32'(x0_cs), 32'h7);
    drain();

    // Request held through a busy cycle
    issue(1'b0, 2'd2, 16'h0, 16'hBEEF);
    rdy_low = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!x0_rdy) rdy_low++;
    end
    @(negedge clk); v0 = 1'b0;
    chk("busy_rdy_low", 32'(rdy_low), 32'd8);
    drain();
    cs_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (x0_cs == 4'b0111) cs_cnt++;
    end
    chk("busy_no_extra_cycle", 32'(cs_cnt), 32'd0);

    // Reset in the middle of a write strobe
    issue(1'b1, 2'd3, 16'h3C3C, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) v0 = 1'b0;
    end
    chk("mid_in_strobe", 32'(x0_wr), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(x0_wr), 32'd1);
    chk("mid_rst_cs", 32'(x0_cs), 32'h8);
    chk("mid_rst_doe", 32'(x0_doe), 32'd0);
    q.delete();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rdy_after", 32'(x0_rdy), 32'd1);
    for (int k = 0; k < 10; k++) @(negedge clk);

    // Short phases on the second instance
    wr_i = 1'b0; a_i = 2'd1; v1 = 1'b1;
    chk("p1_rdy", 32'(x1_rdy), 32'd1);
    @(posedge clk);
    rsp_at = 0; rd_low = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) v1 = 1'b0;
      if (!x1_rd) rd_low++;
      if (x1_rspv && rsp_at == 0) begin
        rsp_at = k;
        chk("p1_rspd", 32'(x1_rspd), 32'h1111);
        chk("p1_rspwr", 32'(x1_rspwr), 32'd0);
      end
    end
    chk("p1_rsp_at", 32'(rsp_at), 32'd4);
    chk("p1_rd_low", 32'(rd_low), 32'd1);

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bsk_prm_bus_master.md
Name: bsk_prm_bus_master

Overview:
- Clocked initiator for the BskPRM parallel peripheral bus (chip-select code, 2-bit address, active-low RD/WR strobes, 16-bit bidirectional data).
- Turns single-word read/write requests on a valid/ready interface into timed bus cycles.
- Returns read data on a one-cycle response pulse.
- Sits between the controller core and the top-level bus pins, which own the tri-state buffer.

Parameters:
- CS_CODE, 4'b0111, chip-select code driven during a cycle; the idle value is ~CS_CODE.
- T_SETUP, 2, clocks of CS/address (and write data) valid before the strobe; must be ≥1.
- T_STROBE, 4, clocks the RD/WR strobe is held low; must be ≥1.
- T_HOLD, 2, clocks of CS/address/data held after the strobe rises; must be ≥1.
- CNT_W, 4, width of the phase counter; each T_* must be ≤ 2^CNT_W.

Ports:
- iClk  in  1  system clock; all state changes on the rising edge.
- iRes  in  1  reset, asynchronous, active-low.
- iReqValid  in  1  request present.
- oReqReady  out  1  request accepted on an edge where iReqValid & oReqReady.
- iReqWr  in  1  1 = write, 0 = read.
- iReqA  in  2  register address.
- iReqD  in  16  write data.
- oRspValid  out  1  one-clock pulse when a cycle completes.
- oRspWr  out  1  type of the completed cycle.
- oRspD  out  16  read data; updated only by reads.
- oCS  out  4  chip-select code to the bus.
- oA  out  2  bus address.
- oRd  out  1  read strobe, active-low.
- oWr  out  1  write strobe, active-low.
- oD  out  16  data to drive onto the bus.
- oDOe  out  1  data output enable, active-high; the pin buffer drives oD when set.
- iD  in  16  data sampled from the bus.

Behaviour:
- Reset, asynchronous on iRes = 0, forces every output:
  - oCS = ~CS_CODE, oA = 0, oRd = 1, oWr = 1, oD = 0, oDOe = 0.
  - oReqReady = 0, oRspValid = 0, oRspWr = 0, oRspD = 0.
  - State goes to IDLE.
  - Reset mid-cycle aborts the cycle immediately, with no response pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, SETUP, STROBE, HOLD. A down-counter is loaded on each phase entry.
- IDLE:
  - oReqReady = 1 in IDLE, including the first clock after iRes deasserts.
  - On accept, latch iReqWr, iReqA and iReqD, then go to SETUP.
- SETUP, T_SETUP clocks:
  - oCS = CS_CODE, oA = latched address.
  - For writes: oD = latched data and oDOe = 1.
- STROBE, T_STROBE clocks:
  - oRd = 0 for reads, oWr = 0 for writes. Exactly one strobe is low, never both.
  - For reads, iD is sampled on the rising edge that ends the last STROBE clock.
- HOLD, T_HOLD clocks:
  - Both strobes are 1.
  - oCS, oA, oD and oDOe are unchanged.
- Leaving HOLD → IDLE:
  - oCS returns to ~CS_CODE and oDOe to 0.
  - oRspValid = 1 for exactly the first IDLE clock, with oRspWr = cycle type.
  - On reads, oRspD = the sampled value and is held until the next read completes.
- oReqReady = 0 in SETUP/STROBE/HOLD; iReqValid is ignored there.
- Back-to-back requests: a new request is accepted in the same IDLE clock that carries oRspValid. That gives a minimum 1-clock gap with CS inactive between cycles.
- Cycle length from accept edge to oRspValid is T_SETUP + T_STROBE + T_HOLD + 1 clocks.
- oDOe is 0 for the whole of any read cycle.

Decomposition:
- Package bsk_prm_pkg holds:
  - typedef state_t {IDLE, SETUP, STROBE, HOLD};
  - BSK_ADDR_W = 2, BSK_DATA_W = 16;
  - register address constants REG_COM_T = 2'b00, REG_COM = 2'b01, REG_COM_IND = 2'b10, REG_CTRL = 2'b11.
- No sub-module; the phase counter lives inline in the single module.

Test Plan:
- Write at defaults: accept {wr, A = 2'b00, D = 16'hA5C3}.
  - oCS = 4'b0111 for 8 clocks.
  - oWr = 0 for exactly 4 clocks, starting 2 clocks after CS.
  - oDOe = 1 for 8 clocks with oD = 16'hA5C3.
  - oRspValid pulses at accept + 9; oRd stays 1 throughout.
- Read REG_CTRL with a bus model returning 16'hA693 only while oRd = 0 (16'h1234 otherwise):
  - oRspD = 16'hA693 and oRspWr = 0 on the pulse.
  - oDOe never asserts.
- Back-to-back: iReqValid held high for write A = 2'b10 then read A = 2'b00.
  - Second accept happens on the oRspValid clock.
  - CS is inactive for exactly 1 clock between the cycles.
  - oRspD is unchanged after the write.
- Request held during a busy cycle: oReqReady = 0 and no second accept until IDLE; exactly one response per accepted request.
- Reset mid-STROBE of a write: within the same clock, oWr = 1, oCS = 4'b1000, oDOe = 0.
  - No oRspValid pulse.
  - After release, oReqReady = 1 on the next clock.
- Parameter override T_SETUP = T_STROBE = T_HOLD = 1:
  - Read completes with oRspValid at accept + 4.
  - oRd is low for exactly 1 clock.
